// File: rtl/pwm_regs_pkg.sv
// pwm_regs_pkg
// Shared register map for the PWM peripheral. Imported by the register
// arbiter and by the SPI peripheral so both agree on addresses and widths.
//   ADDR_W / DATA_W   : register address and data widths
//   ADDR_OUT_*        : output-enable bytes
//   ADDR_PWM_*        : PWM-enable bytes
//   ADDR_DUTY         : double-buffered duty cycle
//   ADDR_MAX          : highest legal address; anything above is an error
//   ADDR_ERR_CLR      : error-counter clear address (optional feature)
package pwm_regs_pkg;

    localparam int ADDR_W        = 4;
    localparam int DATA_W        = 8;

    localparam int ADDR_OUT_7_0  = 0;
    localparam int ADDR_OUT_15_8 = 1;
    localparam int ADDR_PWM_7_0  = 2;
    localparam int ADDR_PWM_15_8 = 3;
    localparam int ADDR_DUTY     = 4;
    localparam int ADDR_MAX      = 4;
    localparam int ADDR_ERR_CLR  = 15;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with a combinational one-hot grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[N]     : request vector
//   grant[N]   : one-hot grant, zero while in reset
//   accept     : grant was consumed this cycle; pointer moves to the winner
// The pointer remembers the last winner; the search starts one past it.
// Until the first grant after reset the search starts at requester 0, so
// requester 0 has top priority even though the pointer itself resets to 0.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    input  logic         accept
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic          started_q;
    logic [PW-1:0] win_idx;
    logic          found;
    int            start_idx;
    int            idx;

    always_comb begin
        grant     = '0;
        win_idx   = '0;
        found     = 1'b0;
        idx       = 0;
        start_idx = 0;
        if (started_q) begin
            start_idx = (int'(ptr_q) + 1 == N) ? 0 : int'(ptr_q) + 1;
        end
        for (int i = 0; i < N; i++) begin
            idx = start_idx + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[PW'(idx)]) begin
                found   = 1'b1;
                win_idx = PW'(idx);
            end
        end
        if (found && rst_n) begin
            grant[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            started_q <= 1'b0;
        end else if (accept && found) begin
            ptr_q     <= win_idx;
            started_q <= 1'b1;
        end
    end

endmodule

// File: rtl/pwm_reg_arbiter.sv
// pwm_reg_arbiter
// Owns the PWM configuration registers and shares write access between
// NUM_REQ requesters through a round-robin valid/ready handshake.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid        : per-requester write request
//   req_addr         : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data         : packed write data, same packing
//   req_ready        : one-hot grant (handshake = valid & ready)
//   period_end       : PWM period wrap pulse; commits a pending duty value
//   en_reg_*         : enable registers, addresses 0..3
//   pwm_duty_cycle   : committed duty cycle (address 4 via shadow)
//   duty_pending     : shadow holds an uncommitted duty value
//   wr_err           : one-cycle pulse after an accepted write above ADDR_MAX
//   err_count        : only with PWM_REG_ERR_COUNT_EN; saturating error count,
//                      cleared by a write to address 0xF
// Optional build macro: PWM_REG_ERR_COUNT_EN.
module pwm_reg_arbiter
    import pwm_regs_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = pwm_regs_pkg::ADDR_W,
    parameter int DATA_W  = pwm_regs_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  period_end,
    output logic [DATA_W-1:0]     en_reg_out_7_0,
    output logic [DATA_W-1:0]     en_reg_out_15_8,
    output logic [DATA_W-1:0]     en_reg_pwm_7_0,
    output logic [DATA_W-1:0]     en_reg_pwm_15_8,
    output logic [DATA_W-1:0]     pwm_duty_cycle,
    output logic                  duty_pending,
`ifdef PWM_REG_ERR_COUNT_EN
    output logic [7:0]            err_count,
`endif
    output logic                  wr_err
);

    logic              wr_any;
    logic              wr_duty;
    logic              wr_bad;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic [DATA_W-1:0] duty_shadow;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .grant  (req_ready),
        .accept (wr_any)
    );

    // Grant stage: select the winning requester's address and data
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
                gnt_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_any  = |req_ready;
    assign wr_duty = wr_any && (gnt_addr == ADDR_W'(ADDR_DUTY));
    assign wr_bad  = wr_any && (gnt_addr >  ADDR_W'(ADDR_MAX));

    // Register stage: enable bank, duty shadow/commit, error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            duty_shadow     <= '0;
            duty_pending    <= 1'b0;
            wr_err          <= 1'b0;
        end else begin
            wr_err <= wr_bad;
            if (wr_any && gnt_addr == ADDR_W'(ADDR_OUT_7_0))  en_reg_out_7_0  <= gnt_data;
            if (wr_any && gnt_addr == ADDR_W'(ADDR_OUT_15_8)) en_reg_out_15_8 <= gnt_data;
            if (wr_any && gnt_addr == ADDR_W'(ADDR_PWM_7_0))  en_reg_pwm_7_0  <= gnt_data;
            if (wr_any && gnt_addr == ADDR_W'(ADDR_PWM_15_8)) en_reg_pwm_15_8 <= gnt_data;

            // Commit uses the shadow value from before this edge, so a duty
            // write coinciding with period_end waits for the next boundary.
            if (period_end && duty_pending) begin
                pwm_duty_cycle <= duty_shadow;
            end
            if (wr_duty) begin
                duty_shadow  <= gnt_data;
                duty_pending <= 1'b1;
            end else if (period_end) begin
                duty_pending <= 1'b0;
            end
        end
    end

`ifdef PWM_REG_ERR_COUNT_EN
    // Counts on the same edge that raises wr_err, so the count and the pulse
    // appear together; the clear write takes priority over its own increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (wr_any && gnt_addr == ADDR_W'(ADDR_ERR_CLR)) begin
            err_count <= '0;
        end else if (wr_bad && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
module tb_pwm_reg_arbiter;

    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            period_end;
    logic [7:0]      o70, o158, p70, p158, duty;
    logic            pend, werr;
`ifdef PWM_REG_ERR_COUNT_EN
    logic [7:0]      err_count;
`endif

    always #5 clk = ~clk;

    pwm_reg_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .period_end      (period_end),
        .en_reg_out_7_0  (o70),
        .en_reg_out_15_8 (o158),
        .en_reg_pwm_7_0  (p70),
        .en_reg_pwm_15_8 (p158),
        .pwm_duty_cycle  (duty),
        .duty_pending    (pend),
`ifdef PWM_REG_ERR_COUNT_EN
        .err_count       (err_count),
`endif
        .wr_err          (werr)
    );

    // Per-requester stimulus
    logic          v [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v[i];
            req_addr[i*AW +: AW]  = a[i];
            req_data[i*DW +: DW]  = d[i];
        end
    end

    // Reference model: register map contents and arbitration history
    logic [7:0] m_reg [4];
    logic [7:0] m_shadow, m_duty;
    logic       m_pend, m_err;
    int         m_cnt;
    int         m_last;
    bit         m_started;

    int checks   = 0;
    int failures = 0;

    function automatic int exp_grant();
        int start;
        if (!rst_n) return -1;
        start = m_started ? (m_last + 1) % N : 0;
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [49:0] obs();
        logic [7:0] ec;
        ec = 8'h00;
`ifdef PWM_REG_ERR_COUNT_EN
        ec = err_count;
`endif
        return {o70, o158, p70, p158, duty, pend, werr, ec};
    endfunction

    function automatic logic [49:0] expv();
        logic [7:0] ec;
        ec = 8'h00;
`ifdef PWM_REG_ERR_COUNT_EN
        ec = 8'(m_cnt);
`endif
        return {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_duty, m_pend, m_err, ec};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_shadow = 8'h00; m_duty = 8'h00; m_pend = 1'b0; m_err = 1'b0;
        m_cnt = 0; m_last = 0; m_started = 1'b0;
    endtask

    task automatic model_update(input int g);
        int addr;
        m_err = 1'b0;
        if (period_end && m_pend) begin
            m_duty = m_shadow;
            m_pend = 1'b0;
        end
        if (g >= 0) begin
            m_last = g; m_started = 1'b1;
            addr = int'(a[g]);
            if (addr <= 3) m_reg[addr] = d[g];
            else if (addr == 4) begin m_shadow = d[g]; m_pend = 1'b1; end
            else m_err = 1'b1;
            if (addr == 15) m_cnt = 0;
            else if (addr > 4 && m_cnt < 255) m_cnt = m_cnt + 1;
        end
    endtask

    // One clock: sample ready before the edge, update model on the edge,
    // return at the next falling edge ready for new stimulus.
    task automatic step(output logic [N-1:0] got_rdy, output logic [N-1:0] exp_rdy, output int g);
        #1;
        g = exp_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        got_rdy = req_ready;
        @(posedge clk);
        model_update(g);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) begin v[i] = 1'b0; a[i] = '0; d[i] = '0; end
        period_end = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [N-1:0] gr, er; int g;
        do_reset();
        rst_n = 1'b0;
        v[0] = 1'b1; a[0] = 4'd2; d[0] = 8'h5A;
        #1;
        checks++;
        if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        checks++;
        if (obs() !== 50'h0) begin failures++; $display("FAIL reset_state got=%h exp=0", obs()); end
        v[0] = 1'b0;
        rst_n = 1'b1;
        step(gr, er, g);
        checks++;
        if (gr !== '0 || obs() !== 50'h0) begin failures++; $display("FAIL idle_no_change ready=%b state=%h exp 0/0", gr, obs()); end
    endtask

    task automatic test_single_write();
        logic [N-1:0] gr, er; int g;
        do_reset();
        v[0] = 1'b1; a[0] = 4'd2; d[0] = 8'hA5;
        step(gr, er, g);
        v[0] = 1'b0;
        checks++;
        if (gr !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", gr); end
        checks++;
        if (obs() !== {8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00})
            begin failures++; $display("FAIL single_regs got=%h exp pwm_7_0=a5 only", obs()); end
    endtask

    task automatic test_alternate();
        logic [N-1:0] gr, er; int g;
        int tbl [4] = '{0, 1, 0, 1};
        do_reset();
        v[0] = 1'b1; v[1] = 1'b1; a[0] = 4'd0; a[1] = 4'd1;
        for (int k = 0; k < 4; k++) begin
            d[0] = 8'(8'h10 + k); d[1] = 8'(8'h20 + k);
            step(gr, er, g);
            checks++;
            if (gr !== 2'(1 << tbl[k])) begin failures++; $display("FAIL alt_grant%0d got=%b exp_idx=%0d", k, gr, tbl[k]); end
            checks++;
            if (obs() !== expv()) begin failures++; $display("FAIL alt_state%0d got=%h exp=%h", k, obs(), expv()); end
        end
        checks++;
        if (o70 !== 8'h12 || o158 !== 8'h23) begin failures++; $display("FAIL alt_final got=%h/%h exp=12/23", o70, o158); end
        idle_inputs();
    endtask

    task automatic test_duty();
        logic [N-1:0] gr, er; int g;
        do_reset();
        v[1] = 1'b1; a[1] = 4'd4; d[1] = 8'h80;
        step(gr, er, g);
        v[1] = 1'b0;
        checks++;
        if (gr !== 2'b10 || pend !== 1'b1 || duty !== 8'h00) begin failures++; $display("FAIL duty_pending got rdy=%b pend=%b duty=%h exp 10/1/00", gr, pend, duty); end
        step(gr, er, g);
        checks++;
        if (pend !== 1'b1 || duty !== 8'h00) begin failures++; $display("FAIL duty_hold got pend=%b duty=%h exp 1/00", pend, duty); end
        period_end = 1'b1;
        step(gr, er, g);
        period_end = 1'b0;
        checks++;
        if (pend !== 1'b0 || duty !== 8'h80) begin failures++; $display("FAIL duty_commit got pend=%b duty=%h exp 0/80", pend, duty); end
        v[0] = 1'b1; a[0] = 4'd4; d[0] = 8'h40;
        step(gr, er, g);
        d[0] = 8'h60; period_end = 1'b1;
        step(gr, er, g);
        v[0] = 1'b0; period_end = 1'b0;
        checks++;
        if (pend !== 1'b1 || duty !== 8'h40) begin failures++; $display("FAIL duty_overlap got pend=%b duty=%h exp 1/40", pend, duty); end
        period_end = 1'b1;
        step(gr, er, g);
        period_end = 1'b0;
        checks++;
        if (pend !== 1'b0 || duty !== 8'h60) begin failures++; $display("FAIL duty_second got pend=%b duty=%h exp 0/60", pend, duty); end
        // Duty write on a period_end with nothing pending: must not commit now
        v[1] = 1'b1; a[1] = 4'd4; d[1] = 8'h11; period_end = 1'b1;
        step(gr, er, g);
        v[1] = 1'b0; period_end = 1'b0;
        checks++;
        if (pend !== 1'b1 || duty !== 8'h60) begin failures++; $display("FAIL duty_nocommit got pend=%b duty=%h exp 1/60", pend, duty); end
        checks++;
        if (obs() !== expv()) begin failures++; $display("FAIL duty_model got=%h exp=%h", obs(), expv()); end
    endtask

    task automatic test_bad_addr();
        logic [N-1:0] gr, er; int g;
        do_reset();
        v[0] = 1'b1; a[0] = 4'd1; d[0] = 8'h3C;
        step(gr, er, g);
        a[0] = 4'd7; d[0] = 8'hFF;
        step(gr, er, g);
        v[0] = 1'b0;
        checks++;
        if (gr !== 2'b01 || werr !== 1'b1) begin failures++; $display("FAIL bad_accept got rdy=%b wr_err=%b exp 01/1", gr, werr); end
        checks++;
        if (o70 !== 8'h00 || o158 !== 8'h3C || p70 !== 8'h00 || p158 !== 8'h00 || duty !== 8'h00)
            begin failures++; $display("FAIL bad_regs got=%h exp only out_15_8=3c", obs()); end
`ifdef PWM_REG_ERR_COUNT_EN
        checks++;
        if (err_count !== 8'd1) begin failures++; $display("FAIL bad_count got=%0d exp=1", err_count); end
`endif
        step(gr, er, g);
        checks++;
        if (werr !== 1'b0) begin failures++; $display("FAIL bad_pulse_width got wr_err=%b exp=0", werr); end
`ifdef PWM_REG_ERR_COUNT_EN
        v[1] = 1'b1; a[1] = 4'd9;
        for (int k = 0; k < 260; k++) step(gr, er, g);
        checks++;
        if (err_count !== 8'd255) begin failures++; $display("FAIL count_saturate got=%0d exp=255", err_count); end
        a[1] = 4'hF;
        step(gr, er, g);
        v[1] = 1'b0;
        checks++;
        if (err_count !== 8'd0 || werr !== 1'b1) begin failures++; $display("FAIL count_clear got=%0d wr_err=%b exp 0/1", err_count, werr); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] gr, er; int g;
        do_reset();
        v[0] = 1'b1; a[0] = 4'd4; d[0] = 8'h33;
        step(gr, er, g);
        a[0] = 4'd0; d[0] = 8'h44;
        step(gr, er, g);
        checks++;
        if (pend !== 1'b1) begin failures++; $display("FAIL mid_setup got pend=%b exp=1", pend); end
        rst_n = 1'b0;
        v[1] = 1'b1; a[1] = 4'd3; d[1] = 8'h77;
        model_reset();
        #1;
        checks++;
        if (req_ready !== '0 || obs() !== 50'h0) begin failures++; $display("FAIL mid_reset got rdy=%b state=%h exp 0/0", req_ready, obs()); end
        @(negedge clk);
        rst_n = 1'b1;
        step(gr, er, g);
        checks++;
        if (gr !== 2'b01) begin failures++; $display("FAIL mid_first_grant got=%b exp=01", gr); end
        v[0] = 1'b0; v[1] = 1'b0; period_end = 1'b1;
        step(gr, er, g);
        period_end = 1'b0;
        checks++;
        if (duty !== 8'h00 || pend !== 1'b0) begin failures++; $display("FAIL mid_stale got duty=%h pend=%b exp 00/0", duty, pend); end
        checks++;
        if (obs() !== expv()) begin failures++; $display("FAIL mid_model got=%h exp=%h", obs(), expv()); end
    endtask

    task automatic test_random();
        logic [N-1:0] gr, er; int g;
        int bad_rdy, bad_state;
        bad_rdy = 0; bad_state = 0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step(gr, er, g);
            if (gr !== er) begin
                bad_rdy++;
                if (bad_rdy <= 3) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", k, gr, er);
            end
            if (obs() !== expv()) begin
                bad_state++;
                if (bad_state <= 3) $display("FAIL rand_state cyc=%0d got=%h exp=%h", k, obs(), expv());
            end
            for (int i = 0; i < N; i++) begin
                if (g == i || !v[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    a[i] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
                    d[i] = 8'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    v[i] = 1'b0;
                end
            end
            period_end = ($urandom_range(0, 4) == 0);
        end
        idle_inputs();
        checks++;
        if (bad_rdy != 0) begin failures++; $display("FAIL rand_ready_total got=%0d exp=0", bad_rdy); end
        checks++;
        if (bad_state != 0) begin failures++; $display("FAIL rand_state_total got=%0d exp=0", bad_state); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_write();
        test_alternate();
        test_duty();
        test_bad_addr();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_reg_arbiter.md
Name: pwm_reg_arbiter

Overview:
- Owns the PWM peripheral's five configuration registers and shares write access between NUM_REQ requesters (SPI peripheral, on-chip sequencer, test port).
- Round-robin arbitration with a valid/ready handshake per requester.
- Duty-cycle writes are double-buffered and commit only at a PWM period boundary, so the PWM never sees a glitched period.
- Sits between the SPI front end and the PWM generator; its outputs drive the PWM datapath directly.

Parameters:
- NUM_REQ, 2, number of write requesters (2..4).
- ADDR_W, 4, register address width.
- DATA_W, 8, register data width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; same packing rule.
- req_ready  output  NUM_REQ  one-hot grant; handshake when valid&ready.
- period_end  input  1  one-cycle pulse from PWM counter at period wrap.
- en_reg_out_7_0  output  8  output-enable bits 7:0 (address 0).
- en_reg_out_15_8  output  8  output-enable bits 15:8 (address 1).
- en_reg_pwm_7_0  output  8  PWM-enable bits 7:0 (address 2).
- en_reg_pwm_15_8  output  8  PWM-enable bits 15:8 (address 3).
- pwm_duty_cycle  output  8  active duty cycle (address 4, shadowed).
- duty_pending  output  1  shadow holds an uncommitted duty value.
- wr_err  output  1  one-cycle pulse when an accepted write has address > 4.

Behaviour:
- Reset: all registers, duty shadow, duty_pending, wr_err and the RR pointer clear to 0. req_ready is 0 while rst_n is low.
- Reset mid-operation: in-flight requests are dropped; requesters must re-present them.
- Arbitration:
  - At most one grant per cycle; req_ready is combinational from req_valid and the RR pointer.
  - Search order starts at pointer+1 modulo NUM_REQ.
  - After reset, requester 0 has highest priority.
  - The pointer updates to the granted index on every handshake and holds otherwise.
- Handshake rule: a requester holds valid, addr and data stable until ready. Deasserting valid before ready is legal and simply withdraws the request.
- Write latency:
  - Addresses 0-3: register updates on the clock edge of the handshake; the new value is visible the following cycle.
  - Address 4: data goes to the duty shadow and duty_pending is set on the same edge.
  - Address > 4: the write is accepted (ready asserted) but discarded; wr_err is registered high for exactly one cycle.
- Duty commit:
  - On period_end with duty_pending=1: pwm_duty_cycle <= shadow, duty_pending <= 0.
  - On period_end with duty_pending=0: no change.
- Boundary conditions:
  - Duty write while pending: shadow is overwritten (last writer wins); pending stays 1.
  - Duty write in the same cycle as period_end with pending=1: the old shadow commits to pwm_duty_cycle; the new data lands in the shadow; pending stays 1.
  - Duty write in the same cycle as period_end with pending=0: the new data goes to the shadow and pending is set. It commits at the next period_end, not the current one.
- No requests: ready is all zero and state is unchanged.
- All requesters valid continuously: each receives exactly one grant every NUM_REQ cycles.

Optional Feature:
- Macro: PWM_REG_ERR_COUNT_EN.
- When defined:
  - Adds output err_count (8 bits), reset 0.
  - Increments on each wr_err pulse and saturates at 255.
  - Clears to 0 on any accepted write to address 0xF; that write still pulses wr_err.
- When undefined: no port and no counter logic; wr_err behaviour is unchanged.

Decomposition:
- Shared package pwm_regs_pkg:
  - Address constants ADDR_OUT_7_0=0, ADDR_OUT_15_8=1, ADDR_PWM_7_0=2, ADDR_PWM_15_8=3, ADDR_DUTY=4, ADDR_MAX=4.
  - Width constants ADDR_W and DATA_W.
  - The SPI peripheral imports the same package.
- One sub-module: rr_arbiter (parameter N; ports clk, rst_n, req[N], grant[N], accept). It contains the pointer and the grant logic.
- Register bank, shadow and error logic stay in the top module.

Test Plan:
- Req0 writes addr 2 data 0xA5 -> ready[0] high in the same cycle; en_reg_pwm_7_0=0xA5 on the next cycle; other registers stay 0.
- Req0 and req1 both valid continuously with distinct addr 0/1 data -> grants alternate 0,1,0,1 starting with req0 after reset; each wins once per 2 cycles.
- Req1 writes addr 4 data 0x80 with no period_end:
  - duty_pending=1 and pwm_duty_cycle stays 0.
  - After a period_end pulse, pwm_duty_cycle=0x80 and duty_pending=0.
- Duty sequence:
  - Write 0x40; then write 0x60 in the same cycle as period_end.
  - pwm_duty_cycle=0x40 and shadow=0x60 with pending=1.
  - At the next period_end, pwm_duty_cycle=0x60.
- Write to addr 7 data 0xFF -> accepted; wr_err pulses for 1 cycle; all registers unchanged. With PWM_REG_ERR_COUNT_EN defined, err_count=1.
- Assert rst_n low while req0 is valid and duty_pending=1 -> all outputs 0 and ready=0 during reset. After release, req0 is granted first and the stale shadow is not committed on period_end.
